// File: rtl/button_reset_conditioner_pkg.sv
// Shared definitions for the push-button conditioners.
// Holds the FSM state encoding, the default timing constants (50 MHz clock)
// and a helper that sizes counters from a cycle count.
package button_reset_conditioner_pkg;

    typedef logic [2:0] btn_state_t;

    localparam btn_state_t ST_IDLE       = 3'd0;
    localparam btn_state_t ST_PRESS_DB   = 3'd1;
    localparam btn_state_t ST_PRESSED    = 3'd2;
    localparam btn_state_t ST_LONG_HELD  = 3'd3;
    localparam btn_state_t ST_RELEASE_DB = 3'd4;

    // 20 ms and 3 s at 50 MHz.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 1_000_000;
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 150_000_000;

    // Counter width for a count of n cycles; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_reset_conditioner_debounce_core.sv
// btn_debounce_core: two-flop synchronizer for the raw button pin, polarity
// normalization, and the debounce counter used by the conditioner FSM.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   btn_raw    asynchronous raw button pin
//   cnt_clr_i  clear the debounce counter this cycle
//   btn_s_o    synchronized button, 1 = pressed
//   cnt_done_o debounce counter has reached DEBOUNCE_CYCLES-1
module btn_debounce_core
    import button_reset_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic cnt_clr_i,
    output logic btn_s_o,
    output logic cnt_done_o
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw pin level while the button is not pressed.
    localparam logic             RAW_IDLE = BTN_ACTIVE_LOW;

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            // Saturate at the terminal count so a long stable period never wraps.
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= RAW_IDLE;
            sync2_q <= RAW_IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_s_o    = sync2_q ^ BTN_ACTIVE_LOW;
    assign cnt_done_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/button_reset_conditioner.sv
// button_reset_conditioner: debounces a push button and classifies presses.
// A press or release is accepted once the synchronized input has been stable
// for DEBOUNCE_CYCLES; a press held for LONG_PRESS_CYCLES raises long_press.
//
// Ports:
//   clk           system clock (50 MHz)
//   rst           synchronous active-low reset
//   btn_raw       asynchronous raw button pin
//   btn_level     debounced level, 1 = pressed (buzzer tone enable)
//   press_pulse   one cycle when a press is accepted
//   release_pulse one cycle when a release is accepted
//   long_press    one cycle when the hold time is reached
//   hold_active   high from long_press until the release is accepted
//   fsm_state_o   current FSM state (debug)
module button_reset_conditioner
    import button_reset_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic       hold_active,
    output logic [2:0] fsm_state_o
);

    localparam int unsigned       HOLD_W    = cnt_width(LONG_PRESS_CYCLES);
    // The debounce time already counts toward the hold, so PRESSED only
    // needs to cover the remainder.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - DEBOUNCE_CYCLES - 1);

    logic              btn_s;
    logic              cnt_done;
    logic              cnt_clr;

    btn_state_t        state_q,   state_d;
    logic [HOLD_W-1:0] hold_q,    hold_d;
    logic              level_q,   level_d;
    logic              press_q,   press_d;
    logic              release_q, release_d;
    logic              long_q,    long_d;
    logic              hact_q,    hact_d;

    btn_debounce_core #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .cnt_clr_i  (cnt_clr),
        .btn_s_o    (btn_s),
        .cnt_done_o (cnt_done)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        level_d   = level_q;
        hact_d    = hact_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        cnt_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_PRESS_DB;
                    cnt_clr = 1'b1;
                end
            end
            ST_PRESS_DB: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_done) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    hold_d  = '0;
                end
            end
            ST_PRESSED: begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (!btn_s) begin
                    state_d = ST_RELEASE_DB;
                    cnt_clr = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_LONG_HELD;
                    long_d  = 1'b1;
                    hact_d  = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_DB;
                    cnt_clr = 1'b1;
                end
            end
            ST_RELEASE_DB: begin
                // Keep timing the hold through a bounce so a brief glitch does
                // not push the long press out.
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (btn_s) begin
                    // hold_active remembers whether the long press already fired.
                    state_d = hact_q ? ST_LONG_HELD : ST_PRESSED;
                end else if (cnt_done) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                    hact_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = 1'b0;
                hact_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            hact_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            hact_q    <= hact_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign hold_active   = hact_q;
    assign fsm_state_o   = state_q;

endmodule

// File: tb/tb_button_reset_conditioner.sv
module tb_button_reset_conditioner;
    import button_reset_conditioner_pkg::*;

    localparam int D = 4;
    localparam int L = 20;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic       hold_active;
    logic [2:0] fsm_state_o;

    int n_checks;
    int n_pass;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    button_reset_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .BTN_ACTIVE_LOW    (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .hold_active   (hold_active),
        .fsm_state_o   (fsm_state_o)
    );

    // ---------------- reference model ----------------
    // Behaviour in terms of the synchronized button samples: the pin reaches
    // the logic two edges after it is applied; a change of the debounced level
    // is accepted once D+1 consecutive samples, all taken after the previous
    // acceptance, disagree with it; the long press fires once the debounced
    // press is L-D edges old and the button is seen pressed on this and the
    // previous sample.
    int   edge_n;
    logic pd1, pd2;
    logic s_prev;
    int   m_run;
    logic m_level, m_long_done;
    int   m_press_edge;
    logic m_press, m_release, m_long;

    task automatic model_edge(input logic raw_v, input logic rst_v);
        logic p;
        logic s_now;
        p = ~raw_v;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_long    = 1'b0;
        if (!rst_v) begin
            pd1 = 1'b0; pd2 = 1'b0; s_prev = 1'b0;
            m_run = 0; m_level = 1'b0; m_long_done = 1'b0;
        end else begin
            s_now = pd2;
            pd2 = pd1;
            pd1 = p;
            if (s_now != m_level) m_run++;
            else m_run = 0;
            if (m_run == D + 1) begin
                if (!m_level) begin
                    m_press = 1'b1;
                    m_press_edge = edge_n;
                end else begin
                    m_release = 1'b1;
                end
                m_level = ~m_level;
                m_long_done = 1'b0;
                m_run = 0;
            end else if (m_level && !m_long_done && (edge_n - m_press_edge >= L - D)
                         && s_now && s_prev) begin
                m_long = 1'b1;
                m_long_done = 1'b1;
            end
            s_prev = s_now;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic raw_v, input logic rst_v);
        btn_raw = raw_v;
        rst     = rst_v;
        @(posedge clk);
        #1;
        edge_n++;
        model_edge(raw_v, rst_v);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        n_checks++; if (btn_level !== 1'b0) $display("FAIL reset_level: got %b expected 0", btn_level); else n_pass++;
        n_checks++; if (press_pulse !== 1'b0) $display("FAIL reset_press: got %b expected 0", press_pulse); else n_pass++;
        n_checks++; if (release_pulse !== 1'b0) $display("FAIL reset_release: got %b expected 0", release_pulse); else n_pass++;
        n_checks++; if (long_press !== 1'b0) $display("FAIL reset_long: got %b expected 0", long_press); else n_pass++;
        n_checks++; if (hold_active !== 1'b0) $display("FAIL reset_hold: got %b expected 0", hold_active); else n_pass++;
        n_checks++; if (fsm_state_o !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", fsm_state_o, ST_IDLE); else n_pass++;
    endtask

    task automatic test_glitch();
        int   activity;
        logic saw_db;
        activity = 0;
        saw_db = 1'b0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int n = 1; n <= 18; n++) begin
            step((n <= 3) ? 1'b0 : 1'b1, 1'b1);
            activity += int'(btn_level) + int'(press_pulse) + int'(release_pulse)
                      + int'(long_press) + int'(hold_active);
            if (fsm_state_o == ST_PRESS_DB) saw_db = 1'b1;
        end
        n_checks++; if (activity !== 0) $display("FAIL glitch_activity: got %0d expected 0", activity); else n_pass++;
        n_checks++; if (saw_db !== 1'b1) $display("FAIL glitch_seen_db: got %b expected 1", saw_db); else n_pass++;
        n_checks++; if (fsm_state_o !== ST_IDLE) $display("FAIL glitch_state: got %0d expected %0d", fsm_state_o, ST_IDLE); else n_pass++;
    endtask

    task automatic test_short_press();
        int   press_at, release_at, press_cnt, release_cnt, long_cnt;
        logic lvl_mid, lvl_pre;
        press_at = -1; release_at = -1; press_cnt = 0; release_cnt = 0; long_cnt = 0;
        lvl_mid = 1'b0; lvl_pre = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            step((n <= 10) ? 1'b0 : 1'b1, 1'b1);
            if (press_pulse)   begin press_cnt++;   press_at = n;   end
            if (release_pulse) begin release_cnt++; release_at = n; end
            if (long_press)    long_cnt++;
            if (n == 10) lvl_mid = btn_level;
            if (n == 16) lvl_pre = btn_level;
        end
        n_checks++; if (press_at !== 7) $display("FAIL short_press_at: got %0d expected 7", press_at); else n_pass++;
        n_checks++; if (press_cnt !== 1) $display("FAIL short_press_cnt: got %0d expected 1", press_cnt); else n_pass++;
        n_checks++; if (lvl_mid !== 1'b1) $display("FAIL short_level_held: got %b expected 1", lvl_mid); else n_pass++;
        n_checks++; if (lvl_pre !== 1'b1) $display("FAIL short_level_pre_release: got %b expected 1", lvl_pre); else n_pass++;
        n_checks++; if (release_at !== 17) $display("FAIL short_release_at: got %0d expected 17", release_at); else n_pass++;
        n_checks++; if (release_cnt !== 1) $display("FAIL short_release_cnt: got %0d expected 1", release_cnt); else n_pass++;
        n_checks++; if (btn_level !== 1'b0) $display("FAIL short_level_end: got %b expected 0", btn_level); else n_pass++;
        n_checks++; if (long_cnt !== 0) $display("FAIL short_no_long: got %0d expected 0", long_cnt); else n_pass++;
    endtask

    task automatic test_long_press();
        int   long_at, long_cnt, release_at;
        logic hold_22, hold_46, hold_47;
        long_at = -1; long_cnt = 0; release_at = -1;
        hold_22 = 1'b1; hold_46 = 1'b0; hold_47 = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            step((n <= 40) ? 1'b0 : 1'b1, 1'b1);
            if (long_press)    begin long_cnt++; long_at = n; end
            if (release_pulse) release_at = n;
            if (n == 22) hold_22 = hold_active;
            if (n == 46) hold_46 = hold_active;
            if (n == 47) hold_47 = hold_active;
        end
        n_checks++; if (long_at !== 23) $display("FAIL long_at: got %0d expected 23", long_at); else n_pass++;
        n_checks++; if (long_cnt !== 1) $display("FAIL long_cnt: got %0d expected 1", long_cnt); else n_pass++;
        n_checks++; if (hold_22 !== 1'b0) $display("FAIL long_hold_before: got %b expected 0", hold_22); else n_pass++;
        n_checks++; if (hold_46 !== 1'b1) $display("FAIL long_hold_during: got %b expected 1", hold_46); else n_pass++;
        n_checks++; if (hold_47 !== 1'b0) $display("FAIL long_hold_cleared: got %b expected 0", hold_47); else n_pass++;
        n_checks++; if (release_at !== 47) $display("FAIL long_release_at: got %0d expected 47", release_at); else n_pass++;
    endtask

    task automatic test_bounce();
        int long_at, release_at, release_cnt, level_drops;
        long_at = -1; release_at = -1; release_cnt = 0; level_drops = 0;
        for (int n = 1; n <= 60; n++) begin
            step((n <= 40 && n != 12 && n != 13) ? 1'b0 : 1'b1, 1'b1);
            if (long_press)    long_at = n;
            if (release_pulse) begin release_cnt++; release_at = n; end
            if (n >= 7 && n <= 46 && !btn_level) level_drops++;
        end
        n_checks++; if (level_drops !== 0) $display("FAIL bounce_level: got %0d low cycles expected 0", level_drops); else n_pass++;
        n_checks++; if (long_at !== 23) $display("FAIL bounce_long_at: got %0d expected 23", long_at); else n_pass++;
        n_checks++; if (release_cnt !== 1) $display("FAIL bounce_release_cnt: got %0d expected 1", release_cnt); else n_pass++;
        n_checks++; if (release_at !== 47) $display("FAIL bounce_release_at: got %0d expected 47", release_at); else n_pass++;
    endtask

    task automatic test_reset_long_held();
        int   press_at, release_cnt;
        logic hold_before;
        press_at = -1; release_cnt = 0;
        for (int n = 1; n <= 30; n++) step(1'b0, 1'b1);
        hold_before = hold_active;
        step(1'b0, 1'b0);
        n_checks++; if (hold_before !== 1'b1) $display("FAIL rst_lh_hold_before: got %b expected 1", hold_before); else n_pass++;
        n_checks++; if (btn_level !== 1'b0) $display("FAIL rst_lh_level: got %b expected 0", btn_level); else n_pass++;
        n_checks++; if (hold_active !== 1'b0) $display("FAIL rst_lh_hold: got %b expected 0", hold_active); else n_pass++;
        n_checks++; if (release_pulse !== 1'b0) $display("FAIL rst_lh_release: got %b expected 0", release_pulse); else n_pass++;
        n_checks++; if ((press_pulse | long_press) !== 1'b0) $display("FAIL rst_lh_pulses: got %b expected 0", press_pulse | long_press); else n_pass++;
        for (int n = 1; n <= 15; n++) begin
            step(1'b0, 1'b1);
            if (press_pulse && press_at < 0) press_at = n;
            if (release_pulse) release_cnt++;
        end
        for (int n = 1; n <= 15; n++) begin
            step(1'b1, 1'b1);
            if (release_pulse) release_cnt++;
        end
        n_checks++; if (press_at !== 7) $display("FAIL rst_lh_new_press_at: got %0d expected 7", press_at); else n_pass++;
        n_checks++; if (release_cnt !== 1) $display("FAIL rst_lh_release_cnt: got %0d expected 1", release_cnt); else n_pass++;
    endtask

    task automatic test_random();
        logic cur_pressed;
        int   len;
        int   steps;
        cur_pressed = 1'b0;
        steps = 0;
        while (steps < 700) begin
            cur_pressed = ~cur_pressed;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 45) : $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                step(~cur_pressed, 1'b1);
                steps++;
                n_checks++; if (press_pulse !== m_press) $display("FAIL rand_press edge %0d: got %b expected %b", edge_n, press_pulse, m_press); else n_pass++;
                n_checks++; if (release_pulse !== m_release) $display("FAIL rand_release edge %0d: got %b expected %b", edge_n, release_pulse, m_release); else n_pass++;
                n_checks++; if (long_press !== m_long) $display("FAIL rand_long edge %0d: got %b expected %b", edge_n, long_press, m_long); else n_pass++;
                n_checks++; if (btn_level !== m_level) $display("FAIL rand_level edge %0d: got %b expected %b", edge_n, btn_level, m_level); else n_pass++;
                n_checks++; if (hold_active !== m_long_done) $display("FAIL rand_hold edge %0d: got %b expected %b", edge_n, hold_active, m_long_done); else n_pass++;
                n_checks++; if ((press_pulse & release_pulse) !== 1'b0) $display("FAIL rand_exclusive edge %0d: got %b expected 0", edge_n, press_pulse & release_pulse); else n_pass++;
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_pass = 0;
        edge_n = 0;
        pd1 = 1'b0; pd2 = 1'b0; s_prev = 1'b0;
        m_run = 0; m_level = 1'b0; m_long_done = 1'b0; m_press_edge = 0;
        m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
        btn_raw = 1'b1;
        rst = 1'b0;
        test_reset();
        test_glitch();
        test_short_press();
        test_long_press();
        test_bounce();
        test_reset_long_held();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_reset_conditioner.md
BUTTON_RESET_CONDITIONER -- requirements
Module: button_reset_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz): the input must be stable for this many cycles before a change is accepted.
REQ-002 Parameter LONG_PRESS_CYCLES, default 150_000_000 (3 s at 50 MHz): the debounced hold time that qualifies as a long press.
REQ-003 Parameter BTN_ACTIVE_LOW, default 1: 1 = the raw pin reads 0 when pressed.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 btn_raw  input  1  asynchronous raw push-button pin.
REQ-007 btn_level  output  1  debounced press level, 1 = pressed; drives the buzzer tone enable (btn_reset).
REQ-008 press_pulse  output  1  one-cycle pulse when a debounced press is accepted.
REQ-009 release_pulse  output  1  one-cycle pulse when a debounced release is accepted.
REQ-010 long_press  output  1  one-cycle pulse when the hold reaches LONG_PRESS_CYCLES.
REQ-011 hold_active  output  1  level, high from the long_press pulse until release is accepted.

Function
REQ-012 btn_raw SHALL pass through a 2-flop synchronizer and then be normalized to active-high (btn_s) per BTN_ACTIVE_LOW before any other use.
REQ-013 The FSM SHALL have the states IDLE, PRESS_DB, PRESSED, LONG_HELD and RELEASE_DB.
REQ-014 IDLE: if btn_s=1, go to PRESS_DB and clear the debounce counter.
REQ-015 PRESS_DB: if btn_s=0, return to IDLE (glitch rejected, no output); when the counter reaches DEBOUNCE_CYCLES-1 with btn_s=1, go to PRESSED.
REQ-016 Entering PRESSED SHALL assert press_pulse for exactly one cycle, set btn_level=1 and clear the hold counter.
REQ-017 PRESSED: the hold counter SHALL increment each cycle; when it reaches LONG_PRESS_CYCLES-DEBOUNCE_CYCLES-1, go to LONG_HELD with long_press pulsed for one cycle and hold_active=1.
REQ-018 PRESSED or LONG_HELD with btn_s=0: go to RELEASE_DB and clear the debounce counter; btn_level stays 1.
REQ-019 RELEASE_DB: if btn_s=1, return to the prior state (PRESSED or LONG_HELD) with the hold counter unchanged; when the counter reaches DEBOUNCE_CYCLES-1 with btn_s=0, go to IDLE, pulse release_pulse, and clear btn_level and hold_active in the same cycle.
REQ-020 long_press SHALL fire at most once per press; LONG_HELD saturates with no further pulses.
REQ-021 Counter widths SHALL come from $clog2 of the parameters; counters SHALL saturate and never wrap.
REQ-022 Latency from a clean raw press edge to press_pulse SHALL be 2 sync cycles + DEBOUNCE_CYCLES + 1 cycles (± 1 cycle); release latency SHALL be identical.
REQ-023 All outputs SHALL be registered; press_pulse and release_pulse SHALL never be high in the same cycle.

Reset
REQ-024 When rst=0 at a clk edge: FSM goes to IDLE, counters clear, synchronizer flops load the not-pressed level, and all outputs are 0.
REQ-025 Reset asserted mid-press SHALL drop btn_level immediately with no release_pulse; a button still held after reset is released SHALL be debounced as a new press.

Structure
REQ-026 The FSM state encoding and the default timing constants SHALL live in the shared project package and be reused by the other button instances.
REQ-027 Synchronizer plus debounce counter SHALL be one sub-module, btn_debounce_core; the FSM and long-press logic SHALL live in the top module.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, BTN_ACTIVE_LOW=1)
REQ-028 Raw low held for 3 cycles then high -> no output activity; FSM back in IDLE.
REQ-029 Raw low held for 10 cycles -> one press_pulse about 7 cycles after the edge and btn_level=1; after release, release_pulse about 7 cycles later and btn_level=0.
REQ-030 Raw low held for 40 cycles -> one long_press pulse about 23 cycles after the edge, hold_active=1 until release is accepted, no second pulse.
REQ-031 While pressed, raw bounces high for 2 cycles -> btn_level stays 1, no release_pulse, long_press timing unchanged.
REQ-032 rst driven low while in LONG_HELD -> next cycle all outputs 0; button kept low through reset release -> fresh press_pulse 7 cycles later.
